// File: rtl/cavlc_nc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cavlc_pkg
// Shared definitions for the CAVLC coeff-token nC sequencer:
//   - seq_state_e : sequencer FSM states
//   - NC_W, TC_W  : widths of nC and TotalCoeff
//   - BLK_PER_MB  : luma 4x4 blocks per macroblock
//   - blk_x/blk_y : z-scan index -> block column/row inside the macroblock
//   - blk_idx     : block column/row -> z-scan index
// ---------------------------------------------------------------------------
package cavlc_pkg;

   localparam int NC_W       = 5;
   localparam int TC_W       = 5;
   localparam int BLK_PER_MB = 16;

   // Valid/ready note: this block has no backpressure handshake. MbStart is a
   // request accepted only in ST_IDLE, TokEnable is a fire-and-forget pulse,
   // and BlkDone is only honoured in ST_WAIT_RES.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CALC      = 3'd1,
      ST_TOKEN     = 3'd2,
      ST_CAPTURE   = 3'd3,
      ST_WAIT_RES  = 3'd4,
      ST_WRITEBACK = 3'd5
   } seq_state_e;

   function automatic logic [1:0] blk_x(input logic [3:0] idx);
      return {idx[2], idx[0]};
   endfunction

   function automatic logic [1:0] blk_y(input logic [3:0] idx);
      return {idx[3], idx[1]};
   endfunction

   function automatic logic [3:0] blk_idx(input logic [1:0] x, input logic [1:0] y);
      return {y[1], x[1], y[0], x[0]};
   endfunction

endpackage

// File: rtl/cavlc_nc_sequencer_nc_calc.sv
// ---------------------------------------------------------------------------
// cavlc_nc_calc
// Combinational nC rule from the left (nA) and top (nB) neighbour counts.
// Ports:
//   i_avail_a, i_na : left neighbour available / its TotalCoeff
//   i_avail_b, i_nb : top neighbour available / its TotalCoeff
//   o_nc            : resulting nC (0..16, never clamped)
// ---------------------------------------------------------------------------
module cavlc_nc_calc
   import cavlc_pkg::*;
(
   input  logic            i_avail_a,
   input  logic [TC_W-1:0] i_na,
   input  logic            i_avail_b,
   input  logic [TC_W-1:0] i_nb,
   output logic [NC_W-1:0] o_nc
);

   // 6-bit sum so that 16+16+1 does not wrap before the halving.
   logic [TC_W:0] w_sum;
   assign w_sum = {1'b0, i_na} + {1'b0, i_nb} + {{TC_W{1'b0}}, 1'b1};

   always_comb begin
      o_nc = '0;
      case ({i_avail_a, i_avail_b})
         2'b11:   o_nc = w_sum[TC_W:1];
         2'b10:   o_nc = i_na;
         2'b01:   o_nc = i_nb;
         default: o_nc = '0;
      endcase
   end

endmodule

// File: rtl/cavlc_nc_sequencer.sv
// ---------------------------------------------------------------------------
// cavlc_nc_sequencer
// Per-macroblock controller for the CAVLC coeff-token stage. Walks the 16
// luma blocks in z-scan order, computes nC from neighbour TotalCoeff values,
// pulses the token decoder, captures its TotalCoeff and waits for the residual
// path before moving on. A line buffer (one 20-bit word per MB column) and a
// left-column register carry neighbour data across macroblocks.
// Ports:
//   Clk, Reset       : clock, synchronous active-high reset
//   MbStart          : start pulse (IDLE only); MbX/MbAvailLeft/MbAvailTop/
//                      MbSkip are sampled with it
//   TotalCoeff       : registered token-decoder result
//   BlkDone          : residual decode of the current block finished
//   nC, TokEnable    : nC for the current block, decoder enable pulse
//   BlkIdx           : z-scan index of the current block
//   Busy, MbDone     : not idle / neighbour state updated
//   DbgState         : current FSM state
// ---------------------------------------------------------------------------
module cavlc_nc_sequencer
   import cavlc_pkg::*;
#(
   parameter int MB_WIDTH_MAX = 120,
   parameter int MBX_W        = 7
)(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             MbStart,
   input  logic [MBX_W-1:0] MbX,
   input  logic             MbAvailLeft,
   input  logic             MbAvailTop,
   input  logic             MbSkip,
   input  logic [TC_W-1:0]  TotalCoeff,
   input  logic             BlkDone,
   output logic [NC_W-1:0]  nC,
   output logic             TokEnable,
   output logic [3:0]       BlkIdx,
   output logic             Busy,
   output logic             MbDone,
   output logic [2:0]       DbgState
);

   seq_state_e        r_state;
   logic [MBX_W-1:0]  r_mbx;
   logic              r_mbx_ok;
   logic              r_avail_left;
   logic              r_avail_top;
   logic [NC_W-1:0]   r_nc;
   logic [3:0]        r_blk_idx;
   logic              r_mb_done;
   logic [TC_W-1:0]   r_cur_tc   [BLK_PER_MB];
   logic [TC_W-1:0]   r_left_col [4];
   logic [4*TC_W-1:0] r_top_row  [MB_WIDTH_MAX];

   logic [1:0]        w_x;
   logic [1:0]        w_y;
   logic              w_avail_a;
   logic              w_avail_b;
   logic [TC_W-1:0]   w_na;
   logic [TC_W-1:0]   w_nb;
   logic [4*TC_W-1:0] w_top_word;
   logic [4*TC_W-1:0] w_wb_word;
   logic [NC_W-1:0]   w_nc;

   // Neighbour selection. Inside the macroblock the z-scan order guarantees
   // that the left/top blocks were already captured into r_cur_tc.
   always_comb begin
      w_x        = blk_x(r_blk_idx);
      w_y        = blk_y(r_blk_idx);
      w_top_word = r_top_row[r_mbx];
      w_avail_a  = 1'b0;
      w_avail_b  = 1'b0;
      w_na       = '0;
      w_nb       = '0;
      if (w_x != 2'd0) begin
         w_avail_a = 1'b1;
         w_na      = r_cur_tc[blk_idx(w_x - 2'd1, w_y)];
      end else if (r_avail_left) begin
         w_avail_a = 1'b1;
         w_na      = r_left_col[w_y];
      end
      if (w_y != 2'd0) begin
         w_avail_b = 1'b1;
         w_nb      = r_cur_tc[blk_idx(w_x, w_y - 2'd1)];
      end else if (r_avail_top && r_mbx_ok) begin
         // An out-of-range column has no line-buffer entry to read.
         w_avail_b = 1'b1;
         w_nb      = w_top_word[TC_W*w_x +: TC_W];
      end
   end

   // Bottom row (y=3) of the macroblock, x=0 in the low bits.
   always_comb begin
      w_wb_word = '0;
      for (int x = 0; x < 4; x++) begin
         w_wb_word[TC_W*x +: TC_W] = r_cur_tc[blk_idx(2'(x), 2'd3)];
      end
   end

   cavlc_nc_calc u_nc_calc (
      .i_avail_a (w_avail_a),
      .i_na      (w_na),
      .i_avail_b (w_avail_b),
      .i_nb      (w_nb),
      .o_nc      (w_nc)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= ST_IDLE;
         r_mbx        <= '0;
         r_mbx_ok     <= 1'b0;
         r_avail_left <= 1'b0;
         r_avail_top  <= 1'b0;
         r_nc         <= '0;
         r_blk_idx    <= '0;
         r_mb_done    <= 1'b0;
         for (int y = 0; y < 4; y++) r_left_col[y] <= '0;
      end else begin
         r_mb_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (MbStart) begin
                  r_mbx        <= MbX;
                  r_mbx_ok     <= (32'(MbX) < MB_WIDTH_MAX);
                  r_avail_left <= MbAvailLeft;
                  r_avail_top  <= MbAvailTop;
                  r_blk_idx    <= '0;
                  r_state      <= MbSkip ? ST_WRITEBACK : ST_CALC;
               end
            end
            ST_CALC: begin
               r_nc    <= w_nc;
               r_state <= ST_TOKEN;
            end
            ST_TOKEN:   r_state <= ST_CAPTURE;
            ST_CAPTURE: r_state <= ST_WAIT_RES;
            ST_WAIT_RES: begin
               if (BlkDone) begin
                  if (r_blk_idx == 4'd15) begin
                     r_state <= ST_WRITEBACK;
                  end else begin
                     r_blk_idx <= r_blk_idx + 4'd1;
                     r_state   <= ST_CALC;
                  end
               end
            end
            ST_WRITEBACK: begin
               if (r_mbx_ok) begin
                  for (int y = 0; y < 4; y++) r_left_col[y] <= r_cur_tc[blk_idx(2'd3, 2'(y))];
               end
               r_mb_done <= 1'b1;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Current-macroblock TotalCoeff store; a skipped MB reads as all zero.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (r_state == ST_IDLE && MbStart && MbSkip) begin
            for (int i = 0; i < BLK_PER_MB; i++) r_cur_tc[i] <= '0;
         end else if (r_state == ST_CAPTURE) begin
            r_cur_tc[r_blk_idx] <= TotalCoeff;
         end
      end
   end

   // Line buffer: single write port, not reset (validity comes from MbAvailTop).
   always_ff @(posedge Clk) begin
      if (!Reset && r_state == ST_WRITEBACK && r_mbx_ok) begin
         r_top_row[r_mbx] <= w_wb_word;
      end
   end

   assign nC        = r_nc;
   assign TokEnable = (r_state == ST_TOKEN);
   assign BlkIdx    = r_blk_idx;
   assign Busy      = (r_state != ST_IDLE);
   assign MbDone    = r_mb_done;
   assign DbgState  = r_state;

endmodule

// File: tb/tb_cavlc_nc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cavlc_nc_sequencer
// Bench for cavlc_nc_sequencer: a behavioural model keeps the neighbour
// state as a per-column bottom-row table and a left column, computes every
// block's nC on a 4x4 grid, and a compare process checks each TokEnable pulse.
// ---------------------------------------------------------------------------
module tb_cavlc_nc_sequencer;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mb_start = 1'b0;
   logic [6:0] mbx = '0;
   logic       al = 1'b0;
   logic       at = 1'b0;
   logic       skip = 1'b0;
   logic [4:0] tc = '0;
   logic       blk_done = 1'b0;
   logic [4:0] nc;
   logic       tok;
   logic [3:0] blk_idx;
   logic       busy;
   logic       mb_done;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   cavlc_nc_sequencer #(.MB_WIDTH_MAX(120), .MBX_W(7)) dut (
      .Clk        (clk),
      .Reset      (rst),
      .MbStart    (mb_start),
      .MbX        (mbx),
      .MbAvailLeft(al),
      .MbAvailTop (at),
      .MbSkip     (skip),
      .TotalCoeff (tc),
      .BlkDone    (blk_done),
      .nC         (nc),
      .TokEnable  (tok),
      .BlkIdx     (blk_idx),
      .Busy       (busy),
      .MbDone     (mb_done),
      .DbgState   (dbg_state)
   );

   // ---------------- scoreboard / model state ----------------
   int         errors = 0;
   int         checks = 0;
   logic [8:0] exp_q[$];        // {blk_idx, nC} per expected TokEnable
   int         obs_nc[16];      // nC seen on the DUT per block of the last MB
   int         tok_seen = 0;
   int         top_row[128][4];
   bit         top_valid[128];
   int         left_col[4];
   bit         left_valid = 1'b1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int nc_rule(input bit a_ok, input int na, input bit b_ok, input int nb);
      if (a_ok && b_ok) return (na + nb + 1) / 2;
      if (a_ok) return na;
      if (b_ok) return nb;
      return 0;
   endfunction

   // Compare process: every TokEnable pulse must match the next expectation.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst && tok) begin
         tok_seen++;
         obs_nc[blk_idx] = int'(nc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tok: got blk %0d nC %0d expected no token", blk_idx, nc);
         end else begin
            e = exp_q.pop_front();
            chk("tok_blk_idx", int'(blk_idx), int'(e[8:5]));
            chk("tok_nc", int'(nc), int'(e[4:0]));
         end
         chk("busy_on_tok", int'(busy), 1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_tok(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (tok) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   // One macroblock. dly = cycles from TokEnable to BlkDone (>=2). noise pulses
   // MbStart+BlkDone in CAPTURE and holds BlkDone into CALC. abort_at >= 0
   // resets the DUT in WAIT_RES of that block.
   task automatic run_mb(input int x, input bit avl, input bit avt, input bit sk,
                         input int tcs[16], input int dly, input bit noise, input int abort_at);
      int grid[4][4];
      int bx, by, na, nb, tok0;
      bit a_ok, b_ok, ok, found;
      for (int yy = 0; yy < 4; yy++) for (int xx = 0; xx < 4; xx++) grid[yy][xx] = 0;
      for (int i = 0; i < 16; i++) obs_nc[i] = -1;
      if (!sk) begin
         for (int i = 0; i < 16; i++) begin
            bx = ((i >> 2) & 1) * 2 + (i & 1);
            by = ((i >> 3) & 1) * 2 + ((i >> 1) & 1);
            a_ok = 1'b0; b_ok = 1'b0; na = 0; nb = 0;
            if (bx > 0) begin a_ok = 1'b1; na = grid[by][bx-1]; end
            else if (avl) begin a_ok = 1'b1; na = left_col[by]; end
            if (by > 0) begin b_ok = 1'b1; nb = grid[by-1][bx]; end
            else if (avt) begin b_ok = 1'b1; nb = top_row[x][bx]; end
            exp_q.push_back({4'(i), 5'(nc_rule(a_ok, na, b_ok, nb))});
            grid[by][bx] = tcs[i];
         end
      end
      tok0 = tok_seen;
      @(negedge clk);
      mbx = 7'(x); al = avl; at = avt; skip = sk; mb_start = 1'b1;
      @(negedge clk);
      mb_start = 1'b0;
      if (sk) begin
         @(negedge clk);
         chk("skip_mbdone_at_2", int'(mb_done), 1);
      end else begin
         for (int i = 0; i < 16; i++) begin
            wait_tok(ok);
            if (!ok) begin
               chk("tok_timeout", 0, 1);
               exp_q.delete();
               return;
            end
            @(negedge clk);                 // CAPTURE: decoder output now valid
            tc = 5'(tcs[i]);
            if (noise) begin
               mb_start = 1'b1; mbx = 7'(x ^ 1); skip = 1'b1; blk_done = 1'b1;
            end
            @(negedge clk);                 // first WAIT_RES cycle
            mb_start = 1'b0; skip = 1'b0; blk_done = 1'b0;
            tc = 5'($urandom_range(0, 31));
            if (i == abort_at) begin
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
               chk("rst_nc", int'(nc), 0);
               chk("rst_tok", int'(tok), 0);
               chk("rst_blk_idx", int'(blk_idx), 0);
               chk("rst_busy", int'(busy), 0);
               chk("rst_mbdone", int'(mb_done), 0);
               exp_q.delete();
               for (int yy = 0; yy < 4; yy++) left_col[yy] = 0;
               left_valid = 1'b1;
               return;
            end
            repeat (dly - 2) @(negedge clk);
            blk_done = 1'b1;
            @(negedge clk);
            if (noise) @(negedge clk);     // BlkDone still high in CALC
            blk_done = 1'b0;
         end
         found = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (mb_done) begin found = 1'b1; break; end
            @(negedge clk);
         end
         chk("mbdone_seen", int'(found), 1);
         chk("tok_count", tok_seen - tok0, 16);
         chk("exp_q_drained", exp_q.size(), 0);
      end
      // model neighbour update
      if (x < 120) begin
         for (int xx = 0; xx < 4; xx++) top_row[x][xx] = grid[3][xx];
         top_valid[x] = 1'b1;
         for (int yy = 0; yy < 4; yy++) left_col[yy] = grid[yy][3];
         left_valid = 1'b1;
      end else begin
         left_valid = 1'b0;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t[16];
      int x, dly;
      bit sk, avl, avt, nz;
      for (int i = 0; i < 128; i++) top_valid[i] = 1'b0;
      for (int i = 0; i < 4; i++) left_col[i] = 0;

      repeat (3) @(negedge clk);
      chk("reset_nc", int'(nc), 0);
      chk("reset_tok", int'(tok), 0);
      chk("reset_blk_idx", int'(blk_idx), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_mbdone", int'(mb_done), 0);
      rst = 1'b0;

      // S1: no availability, TotalCoeff=3 everywhere
      for (int i = 0; i < 16; i++) t[i] = 3;
      run_mb(0, 0, 0, 0, t, 2, 0, -1);
      chk("s1_blk0_nc", obs_nc[0], 0);
      chk("s1_blk1_nc", obs_nc[1], 3);
      chk("s1_blk3_nc", obs_nc[3], 3);

      // S2: skipped MB at 4, then MB 5 using its zero left column
      run_mb(4, 0, 0, 1, t, 2, 0, -1);
      for (int i = 0; i < 16; i++) t[i] = $urandom_range(0, 16);
      run_mb(5, 1, 0, 0, t, 3, 0, -1);
      chk("s2_blk0_nc", obs_nc[0], 0);

      // S3: bottom row 8,8,8,8 at column 2, then next row reads it
      for (int i = 0; i < 16; i++) t[i] = 8;
      run_mb(2, 0, 0, 0, t, 2, 0, -1);
      for (int i = 0; i < 16; i++) t[i] = $urandom_range(0, 16);
      t[0] = 2;
      run_mb(2, 0, 1, 0, t, 2, 0, -1);
      chk("s3_blk0_nc", obs_nc[0], 8);
      chk("s3_blk1_nc", obs_nc[1], 5);

      // S6: both neighbours 16
      for (int i = 0; i < 16; i++) t[i] = 16;
      run_mb(10, 0, 0, 0, t, 2, 0, -1);
      run_mb(10, 1, 1, 0, t, 2, 0, -1);
      chk("s6_blk0_nc", obs_nc[0], 16);

      // S4: left column 9, then reset in WAIT_RES of block 7, fresh MB
      for (int i = 0; i < 16; i++) t[i] = 9;
      run_mb(3, 0, 0, 0, t, 2, 0, -1);
      run_mb(6, 1, 0, 0, t, 2, 0, 7);
      for (int i = 0; i < 16; i++) t[i] = $urandom_range(1, 16);
      run_mb(6, 1, 0, 0, t, 2, 0, -1);
      chk("s4_blk0_left_cleared", obs_nc[0], 0);

      // S5: spurious MbStart in CAPTURE and BlkDone in CALC
      for (int i = 0; i < 16; i++) t[i] = $urandom_range(0, 16);
      run_mb(7, 1, 0, 0, t, 2, 1, -1);

      // Out-of-range column: completes, write-back suppressed
      run_mb(120, 0, 0, 0, t, 2, 0, -1);

      // Randomized macroblocks
      for (int n = 0; n < 40; n++) begin
         x   = $urandom_range(0, 7);
         sk  = ($urandom_range(0, 4) == 0);
         avl = left_valid && ($urandom_range(0, 1) == 1);
         avt = top_valid[x] && ($urandom_range(0, 1) == 1);
         nz  = ($urandom_range(0, 3) == 0);
         dly = $urandom_range(2, 4);
         for (int i = 0; i < 16; i++)
            t[i] = (n % 2 == 0) ? $urandom_range(0, 16) : $urandom_range(12, 16);
         run_mb(x, avl, avt, sk, t, dly, nz, -1);
      end

      repeat (3) @(negedge clk);
      chk("final_exp_q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
